id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised decode stage with a built-in ID/EXE output register.
- Decodes one instruction per accepted transfer:
  - data-processing, memory and branch control fields;
  - ARM condition check against the status flags;
  - register-file read with write-back bypass.
- Valid/ready handshake on both sides; supports hazard stall, branch flush and a saturating squash counter.
- Sits between IF and EXE stages.

Parameters:
DATA_W, 32, register/operand/PC width
REG_ADDR_W, 4, register index width
NUM_REGS, 16, implemented registers (≤ 2^REG_ADDR_W)
SQ_CNT_W, 16, squash counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  instruction/pc_in valid
in_ready  out  1  stage can accept this cycle
instruction  in  32  ARM instruction
pc_in  in  DATA_W  PC of instruction
status_reg  in  4  {N,Z,C,V} = bits [3:0]
hazard  in  1  operand hazard, stall acceptance
flush  in  1  branch taken, discard contents
wb_wb_en  in  1  register write enable
wb_dest  in  REG_ADDR_W  write index
wb_value  in  DATA_W  write data
out_valid  out  1  output register holds an instruction
out_ready  in  1  EXE accepts output
pc_out  out  DATA_W  registered PC
mem_r_en, mem_w_en, wb_en, b, s  out  1 each  registered control
exe_cmd  out  4  registered ALU command
src1, src2, dest  out  REG_ADDR_W  registered indices
imm, two_src  out  1 each  registered flags
shift_operand  out  12  instruction[11:0]
signed_imm_24  out  24  instruction[23:0]
val_rn, val_rm  out  DATA_W  registered operand values
squash_cnt  out  SQ_CNT_W  count of condition-failed instructions

Behaviour:
- Reset (rst=0 at edge):
  - all outputs and register-file entries go to 0;
  - out_valid=0 and squash_cnt=0.
- Combinational handshake:
  - in_ready = rst & ~hazard & (~out_valid | out_ready) | flush.
  - Accept = in_valid & in_ready.
- Latency: an accepted instruction appears on the outputs on the next edge, with out_valid=1 (one cycle).
- Output register update, first matching rule applies:
  1. flush=1 → out_valid←0; any input accepted that cycle is discarded.
  2. Accept → capture all fields, out_valid←1.
  3. out_ready=1 and no accept → out_valid←0. A hazard-driven bubble always has out_valid=0.
  4. Otherwise hold all outputs.
- Field decode:
  - Field sources: src1=instr[19:16], dest=instr[15:12], imm=instr[25], mode=instr[27:26], op=instr[24:21], S=instr[20].
  - src2 = dest if mem_w_en, else instr[3:0].
  - two_src = mem_w_en | ~imm.
- mode 00 (data processing), op→exe_cmd, wb_en=1 unless noted:
  - MOV 1101→0001; MVN 1111→1001; ADD 0100→0010; ADC 0101→0011;
  - SUB 0010→0100; SBC 0110→0101; AND 0000→0110; ORR 1100→0111; EOR 0001→1000;
  - CMP 1010→0100, wb_en=0, s forced 1; TST 1000→0110, wb_en=0, s forced 1;
  - other op → all control 0.
  - s = S for the non-compare opcodes.
- mode 01 (memory): exe_cmd=0010; S=1 gives LDR (mem_r_en=1, wb_en=1); S=0 gives STR (mem_w_en=1).
- mode 10 (branch): b=1, all other control 0.
- mode 11: all control 0.
- Condition instr[31:28], evaluated on status_reg at accept:
  - EQ/NE Z; CS/CC C; MI/PL N; VS/VC V;
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V);
  - 1110 always; 1111 never.
- Condition fail:
  - instruction still accepted with out_valid=1;
  - mem_r_en, mem_w_en, wb_en, b, s, exe_cmd all 0; other fields captured normally;
  - squash_cnt increments, saturating at all-ones. A flushed accept does not count.
- Register file:
  - NUM_REGS × DATA_W; write on edge when wb_wb_en=1 and wb_dest<NUM_REGS, otherwise ignored.
  - Combinational read: index ≥ NUM_REGS returns 0.
  - Read index == wb_dest with wb_wb_en=1 in the same cycle returns wb_value (bypass).
- Writes proceed regardless of stall/flush.
- Reset mid-stream drops the held instruction.

Test Plan:
- Reset, then feed instr 0xE3A01005 (MOV R1,#5) with out_ready=1 → next cycle out_valid=1, exe_cmd=0001, wb_en=1, imm=1, dest=1, two_src=0.
- Write R2=0x1234 with wb_wb_en=1 and accept ADD R3,R2,R2 (0xE0823002) in the same cycle → val_rn=val_rm=0x1234 via bypass.
- status_reg=0000, accept 0x03A01005 (MOVEQ) → out_valid=1, all control 0, squash_cnt=1; with Z=1 → wb_en=1, squash_cnt unchanged.
- Hold out_ready=0 with out_valid=1 → in_ready=0 and outputs stable for 3 cycles; assert hazard=1 with out_ready=1 → out_valid=0 next cycle, in_ready=0.
- Accept STR 0xE5801000 while flush=1 → out_valid=0 next cycle, squash_cnt unchanged; next STR without flush → mem_w_en=1, src2=1, two_src=1.
- With SQ_CNT_W=2, send 5 condition-failed instructions → squash_cnt saturates at 3; rst=0 for one edge → squash_cnt=0, out_valid=0, R1..R15 read 0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM-style instruction decode stage with a built-in ID/EXE
// output register, condition check against status flags, a register file
// with write-back bypass, and a saturating counter of condition-failed
// instructions.
//
// Handshake: a transfer into the stage happens on a rising edge when
// in_valid & in_ready are both 1 (flush forces in_ready high so IF can drain,
// but whatever is accepted under flush is dropped). The output register holds
// its contents while out_valid=1 and out_ready=0; out_valid never depends
// combinationally on out_ready.
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int NUM_REGS   = 16,
  parameter int SQ_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [3:0]            status_reg,
  input  logic                  hazard,
  input  logic                  flush,
  input  logic                  wb_wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]     wb_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     pc_out,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic                  wb_en,
  output logic                  b,
  output logic                  s,
  output logic [3:0]            exe_cmd,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  imm,
  output logic                  two_src,
  output logic [11:0]           shift_operand,
  output logic [23:0]           signed_imm_24,
  output logic [DATA_W-1:0]     val_rn,
  output logic [DATA_W-1:0]     val_rm,
  output logic [SQ_CNT_W-1:0]   squash_cnt
);

  // When every index is implemented the range check collapses to 1.
  localparam bit FULL_RF = (NUM_REGS == (1 << REG_ADDR_W));

  function automatic logic rf_in_range(input logic [REG_ADDR_W-1:0] idx);
    if (FULL_RF) return 1'b1;
    return (32'(idx) < NUM_REGS);
  endfunction

  // Register file and output register state
  logic [DATA_W-1:0]     r_regs [NUM_REGS];
  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_pc;
  logic                  r_mem_r_en, r_mem_w_en, r_wb_en, r_b, r_s;
  logic [3:0]            r_exe_cmd;
  logic [REG_ADDR_W-1:0] r_src1, r_src2, r_dest;
  logic                  r_imm, r_two_src;
  logic [11:0]           r_shift_operand;
  logic [23:0]           r_signed_imm_24;
  logic [DATA_W-1:0]     r_val_rn, r_val_rm;
  logic [SQ_CNT_W-1:0]   r_squash_cnt;

  // Decode wires
  logic [1:0]            w_mode;
  logic [3:0]            w_op;
  logic                  w_sbit;
  logic [3:0]            w_cond;
  logic                  w_cmd_mr, w_cmd_mw, w_cmd_wb, w_cmd_b, w_cmd_s;
  logic [3:0]            w_cmd_exe;
  logic                  w_cond_ok;
  logic [REG_ADDR_W-1:0] w_src1, w_src2, w_dest;
  logic                  w_imm;
  logic                  w_accept;
  logic [DATA_W-1:0]     w_val_rn, w_val_rm;

  assign w_mode = instruction[27:26];
  assign w_op   = instruction[24:21];
  assign w_sbit = instruction[20];
  assign w_cond = instruction[31:28];
  assign w_imm  = instruction[25];
  assign w_src1 = REG_ADDR_W'(instruction[19:16]);
  assign w_dest = REG_ADDR_W'(instruction[15:12]);
  // Stores read the data register through the second port.
  assign w_src2 = w_cmd_mw ? w_dest : REG_ADDR_W'(instruction[3:0]);

  assign in_ready = (rst & ~hazard & (~r_out_valid | out_ready)) | flush;
  assign w_accept = in_valid & in_ready;

  // Control decode from mode/opcode/S, before the condition check
  always_comb begin
    w_cmd_exe = 4'b0000;
    w_cmd_mr  = 1'b0;
    w_cmd_mw  = 1'b0;
    w_cmd_wb  = 1'b0;
    w_cmd_b   = 1'b0;
    w_cmd_s   = 1'b0;
    case (w_mode)
      2'b00: begin
        w_cmd_wb = 1'b1;
        w_cmd_s  = w_sbit;
        case (w_op)
          4'b1101: w_cmd_exe = 4'b0001; // MOV
          4'b1111: w_cmd_exe = 4'b1001; // MVN
          4'b0100: w_cmd_exe = 4'b0010; // ADD
          4'b0101: w_cmd_exe = 4'b0011; // ADC
          4'b0010: w_cmd_exe = 4'b0100; // SUB
          4'b0110: w_cmd_exe = 4'b0101; // SBC
          4'b0000: w_cmd_exe = 4'b0110; // AND
          4'b1100: w_cmd_exe = 4'b0111; // ORR
          4'b0001: w_cmd_exe = 4'b1000; // EOR
          4'b1010: begin                // CMP
            w_cmd_exe = 4'b0100;
            w_cmd_wb  = 1'b0;
            w_cmd_s   = 1'b1;
          end
          4'b1000: begin                // TST
            w_cmd_exe = 4'b0110;
            w_cmd_wb  = 1'b0;
            w_cmd_s   = 1'b1;
          end
          default: begin
            w_cmd_wb = 1'b0;
            w_cmd_s  = 1'b0;
          end
        endcase
      end
      2'b01: begin
        w_cmd_exe = 4'b0010;
        w_cmd_mr  = w_sbit;
        w_cmd_wb  = w_sbit;
        w_cmd_mw  = ~w_sbit;
      end
      2'b10:   w_cmd_b = 1'b1;
      default: ;
    endcase
  end

  // ARM condition evaluation on {N,Z,C,V}
  always_comb begin
    w_cond_ok = 1'b0;
    case (w_cond)
      4'b0000: w_cond_ok = status_reg[2];
      4'b0001: w_cond_ok = ~status_reg[2];
      4'b0010: w_cond_ok = status_reg[1];
      4'b0011: w_cond_ok = ~status_reg[1];
      4'b0100: w_cond_ok = status_reg[3];
      4'b0101: w_cond_ok = ~status_reg[3];
      4'b0110: w_cond_ok = status_reg[0];
      4'b0111: w_cond_ok = ~status_reg[0];
      4'b1000: w_cond_ok = status_reg[1] & ~status_reg[2];
      4'b1001: w_cond_ok = ~status_reg[1] | status_reg[2];
      4'b1010: w_cond_ok = (status_reg[3] == status_reg[0]);
      4'b1011: w_cond_ok = (status_reg[3] != status_reg[0]);
      4'b1100: w_cond_ok = ~status_reg[2] & (status_reg[3] == status_reg[0]);
      4'b1101: w_cond_ok = status_reg[2] | (status_reg[3] != status_reg[0]);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  // Port 1 read (Rn) with same-cycle write-back bypass
  always_comb begin
    w_val_rn = '0;
    if (rf_in_range(w_src1)) begin
      if (wb_wb_en && (wb_dest == w_src1)) w_val_rn = wb_value;
      else                                 w_val_rn = r_regs[w_src1];
    end
  end

  // Port 2 read (Rm or store data) with same-cycle write-back bypass
  always_comb begin
    w_val_rm = '0;
    if (rf_in_range(w_src2)) begin
      if (wb_wb_en && (wb_dest == w_src2)) w_val_rm = wb_value;
      else                                 w_val_rm = r_regs[w_src2];
    end
  end

  // Register file write port; independent of stall and flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_wb_en && rf_in_range(wb_dest)) begin
      r_regs[wb_dest] <= wb_value;
    end
  end

  // ID/EXE output register: flush, then accept, then drain, else hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid     <= 1'b0;
      r_pc            <= '0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_wb_en         <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_exe_cmd       <= '0;
      r_src1          <= '0;
      r_src2          <= '0;
      r_dest          <= '0;
      r_imm           <= 1'b0;
      r_two_src       <= 1'b0;
      r_shift_operand <= '0;
      r_signed_imm_24 <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid     <= 1'b1;
      r_pc            <= pc_in;
      // A failed condition turns the instruction into a no-op for EXE.
      r_mem_r_en      <= w_cmd_mr & w_cond_ok;
      r_mem_w_en      <= w_cmd_mw & w_cond_ok;
      r_wb_en         <= w_cmd_wb & w_cond_ok;
      r_b             <= w_cmd_b & w_cond_ok;
      r_s             <= w_cmd_s & w_cond_ok;
      r_exe_cmd       <= w_cond_ok ? w_cmd_exe : 4'b0000;
      r_src1          <= w_src1;
      r_src2          <= w_src2;
      r_dest          <= w_dest;
      r_imm           <= w_imm;
      r_two_src       <= w_cmd_mw | ~w_imm;
      r_shift_operand <= instruction[11:0];
      r_signed_imm_24 <= instruction[23:0];
      r_val_rn        <= w_val_rn;
      r_val_rm        <= w_val_rm;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating count of accepted, non-flushed, condition-failed instructions
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_squash_cnt <= '0;
    end else if (w_accept && !flush && !w_cond_ok && (r_squash_cnt != '1)) begin
      r_squash_cnt <= r_squash_cnt + SQ_CNT_W'(1);
    end
  end

  assign out_valid     = r_out_valid;
  assign pc_out        = r_pc;
  assign mem_r_en      = r_mem_r_en;
  assign mem_w_en      = r_mem_w_en;
  assign wb_en         = r_wb_en;
  assign b             = r_b;
  assign s             = r_s;
  assign exe_cmd       = r_exe_cmd;
  assign src1          = r_src1;
  assign src2          = r_src2;
  assign dest          = r_dest;
  assign imm           = r_imm;
  assign two_src       = r_two_src;
  assign shift_operand = r_shift_operand;
  assign signed_imm_24 = r_signed_imm_24;
  assign val_rn        = r_val_rn;
  assign val_rm        = r_val_rm;
  assign squash_cnt    = r_squash_cnt;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: decode-table vectors, directed multi-cycle sequences and
// randomized traffic against a behavioural model of the decode stage.
module tb_id_stage_pipe;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_rst, t_in_valid, t_hazard, t_flush, t_wb_en, t_out_ready;
  logic [31:0] t_instr, t_pc, t_wb_value;
  logic [3:0]  t_status, t_wb_dest;

  logic        in_ready, out_valid, mem_r_en, mem_w_en, wb_en, b, s, imm, two_src;
  logic [31:0] pc_out, val_rn, val_rm;
  logic [3:0]  exe_cmd, src1, src2, dest;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [1:0]  squash_cnt;

  id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(4), .NUM_REGS(16), .SQ_CNT_W(2)) dut (
    .clk(clk), .rst(t_rst), .in_valid(t_in_valid), .in_ready(in_ready),
    .instruction(t_instr), .pc_in(t_pc), .status_reg(t_status),
    .hazard(t_hazard), .flush(t_flush), .wb_wb_en(t_wb_en),
    .wb_dest(t_wb_dest), .wb_value(t_wb_value), .out_valid(out_valid),
    .out_ready(t_out_ready), .pc_out(pc_out), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .wb_en(wb_en), .b(b), .s(s), .exe_cmd(exe_cmd),
    .src1(src1), .src2(src2), .dest(dest), .imm(imm), .two_src(two_src),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .val_rn(val_rn), .val_rm(val_rm), .squash_cnt(squash_cnt)
  );

  typedef struct packed {
    logic        ov;
    logic [31:0] pc;
    logic        mr, mw, wb, bb, ss;
    logic [3:0]  cmd, s1, s2, dst;
    logic        im, two;
    logic [11:0] sh;
    logic [23:0] si;
    logic [31:0] vrn, vrm;
    logic [1:0]  cnt;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [3:0]  cmd;
    logic        wb, mr, mw, bb, ss;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural reference model ----------------
  out_t        m;
  logic [31:0] m_regs [16];
  logic [3:0]  dp_cmd [16];
  int          dp_kind [16];  // 0 = not decoded, 1 = ALU writes Rd, 2 = compare

  function automatic out_t dut_out();
    out_t o;
    o = {out_valid, pc_out, mem_r_en, mem_w_en, wb_en, b, s, exe_cmd, src1, src2,
         dest, imm, two_src, shift_operand, signed_imm_24, val_rn, val_rm, squash_cnt};
    return o;
  endfunction

  // Even codes test a flag expression, odd codes its complement; 1110/1111 always/never.
  function automatic bit cond_pass(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [31:0] m_read(logic [3:0] idx);
    if (t_wb_en && idx == t_wb_dest) return t_wb_value;
    return m_regs[idx];
  endfunction

  function automatic logic exp_ready();
    return (t_rst && !t_hazard && (!m.ov || t_out_ready)) || t_flush;
  endfunction

  function automatic out_t model_next();
    out_t nx;
    bit acc, ok;
    logic [1:0] mode;
    logic [3:0] op;
    logic sb, mr, mw, wb, bb, ss;
    logic [3:0] cmd;
    nx = m;
    if (!t_rst) return '0;
    acc = t_in_valid && exp_ready();
    ok = cond_pass(t_instr[31:28], t_status);
    if (t_flush) nx.ov = 1'b0;
    else if (acc) begin
      mode = t_instr[27:26]; op = t_instr[24:21]; sb = t_instr[20];
      {mr, mw, wb, bb, ss, cmd} = '0;
      if (mode == 2'b00 && dp_kind[op] != 0) begin
        cmd = dp_cmd[op];
        wb  = (dp_kind[op] == 1);
        ss  = (dp_kind[op] == 2) ? 1'b1 : sb;
      end else if (mode == 2'b01) begin
        cmd = 4'd2; mr = sb; wb = sb; mw = !sb;
      end else if (mode == 2'b10) bb = 1'b1;
      nx.ov  = 1'b1;
      nx.pc  = t_pc;
      nx.s1  = t_instr[19:16];
      nx.dst = t_instr[15:12];
      nx.im  = t_instr[25];
      nx.s2  = mw ? t_instr[15:12] : t_instr[3:0];
      nx.two = mw || !t_instr[25];
      nx.sh  = t_instr[11:0];
      nx.si  = t_instr[23:0];
      nx.vrn = m_read(nx.s1);
      nx.vrm = m_read(nx.s2);
      if (ok) {nx.mr, nx.mw, nx.wb, nx.bb, nx.ss, nx.cmd} = {mr, mw, wb, bb, ss, cmd};
      else    {nx.mr, nx.mw, nx.wb, nx.bb, nx.ss, nx.cmd} = '0;
    end else if (t_out_ready) nx.ov = 1'b0;
    if (acc && !t_flush && !ok && nx.cnt != 2'b11) nx.cnt = nx.cnt + 2'd1;
    return nx;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: check in_ready, advance model, check registered outputs.
  task automatic cycle();
    out_t nx;
    #1;
    check("in_ready", 160'(in_ready), 160'(exp_ready()));
    nx = model_next();
    @(posedge clk);
    m = nx;
    if (!t_rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
    end else if (t_wb_en) m_regs[t_wb_dest] = t_wb_value;
    #1;
    check("outs", 160'(dut_out()), 160'(m));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    t_rst = 1'b1; t_in_valid = 1'b0; t_hazard = 1'b0; t_flush = 1'b0;
    t_wb_en = 1'b0; t_out_ready = 1'b1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    t_in_valid = 1'b1; t_instr = ins; t_pc = pc;
    cycle();
    t_in_valid = 1'b0;
  endtask

  vec_t vt [20];
  out_t snap;
  logic [1:0] cnt_before;

  initial begin
    // opcode -> command table for data processing
    for (int i = 0; i < 16; i++) begin dp_cmd[i] = '0; dp_kind[i] = 0; end
    dp_cmd[13] = 4'd1; dp_kind[13] = 1;  // MOV
    dp_cmd[15] = 4'd9; dp_kind[15] = 1;  // MVN
    dp_cmd[4]  = 4'd2; dp_kind[4]  = 1;  // ADD
    dp_cmd[5]  = 4'd3; dp_kind[5]  = 1;  // ADC
    dp_cmd[2]  = 4'd4; dp_kind[2]  = 1;  // SUB
    dp_cmd[6]  = 4'd5; dp_kind[6]  = 1;  // SBC
    dp_cmd[0]  = 4'd6; dp_kind[0]  = 1;  // AND
    dp_cmd[12] = 4'd7; dp_kind[12] = 1;  // ORR
    dp_cmd[1]  = 4'd8; dp_kind[1]  = 1;  // EOR
    dp_cmd[10] = 4'd4; dp_kind[10] = 2;  // CMP
    dp_cmd[8]  = 4'd6; dp_kind[8]  = 2;  // TST

    //             instr         flags    cmd    wb    mr    mw    b     s
    vt[0]  = '{32'hE3A01005, 4'b0000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // MOV
    vt[1]  = '{32'hE1E01002, 4'b0000, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // MVN
    vt[2]  = '{32'hE0923002, 4'b0000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // ADDS
    vt[3]  = '{32'hE0A23002, 4'b0000, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // ADC
    vt[4]  = '{32'hE0423002, 4'b0000, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // SUB
    vt[5]  = '{32'hE0C23002, 4'b0000, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // SBC
    vt[6]  = '{32'hE0023002, 4'b0000, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // AND
    vt[7]  = '{32'hE1823002, 4'b0000, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // ORR
    vt[8]  = '{32'hE0223002, 4'b0000, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // EOR
    vt[9]  = '{32'hE1520003, 4'b0000, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // CMP
    vt[10] = '{32'hE1120003, 4'b0000, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // TST
    vt[11] = '{32'hE0623002, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // RSB: undecoded
    vt[12] = '{32'hE5912000, 4'b0000, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // LDR
    vt[13] = '{32'hE5812000, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // STR
    vt[14] = '{32'hEA000010, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // B
    vt[15] = '{32'hEF000000, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // mode 11
    vt[16] = '{32'hC3A01005, 4'b1001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // MOVGT pass
    vt[17] = '{32'hD3A01005, 4'b1001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // MOVLE fail
    vt[18] = '{32'hF3A01005, 4'b1111, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // never
    vt[19] = '{32'h83A01005, 4'b0010, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // MOVHI pass

    m = '0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    idle();
    t_instr = '0; t_pc = '0; t_status = '0; t_wb_dest = '0; t_wb_value = '0;

    // Reset
    t_rst = 1'b0;
    cycle(); cycle();
    check("reset_state", 160'({out_valid, squash_cnt}), 160'(0));
    t_rst = 1'b1;

    // MOV R1,#5
    send(32'hE3A01005, 32'h0000_0010);
    check("mov", 160'({out_valid, exe_cmd, wb_en, imm, dest, two_src}),
          160'({1'b1, 4'b0001, 1'b1, 1'b1, 4'd1, 1'b0}));

    // ADD R3,R2,R2 with R2 written the same cycle
    t_wb_en = 1'b1; t_wb_dest = 4'd2; t_wb_value = 32'h1234;
    send(32'hE0823002, 32'h0000_0014);
    t_wb_en = 1'b0;
    check("bypass", 160'({val_rn, val_rm}), 160'({32'h1234, 32'h1234}));

    // MOVEQ with Z=0 fails, then with Z=1 passes
    t_status = 4'b0000;
    send(32'h03A01005, 32'h0000_0018);
    check("cond_fail", 160'({out_valid, mem_r_en, mem_w_en, wb_en, b, s, exe_cmd, squash_cnt}),
          160'({1'b1, 5'b0, 4'b0, 2'd1}));
    t_status = 4'b0100;
    send(32'h03A01005, 32'h0000_001C);
    check("cond_pass", 160'({wb_en, squash_cnt}), 160'({1'b1, 2'd1}));

    // Decode table
    for (int i = 0; i < 20; i++) begin
      t_status = vt[i].flags;
      send(vt[i].instr, 32'h100 + 32'(i) * 4);
      check($sformatf("vec%0d", i), 160'({exe_cmd, wb_en, mem_r_en, mem_w_en, b, s}),
            160'({vt[i].cmd, vt[i].wb, vt[i].mr, vt[i].mw, vt[i].bb, vt[i].ss}));
    end

    // Back-pressure: held output, no acceptance
    t_status = 4'b0000;
    cycle();                              // drain
    t_out_ready = 1'b0;
    send(32'hE3A01005, 32'h0000_0200);
    snap = dut_out();
    t_in_valid = 1'b1; t_instr = 32'hE0823002; t_pc = 32'h0000_0204;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_ready", 160'(in_ready), 160'(0));
      check("stall_hold", 160'(dut_out()), 160'(snap));
    end
    // Hazard with EXE ready: bubble
    t_hazard = 1'b1; t_out_ready = 1'b1;
    cycle();
    check("hazard_bubble", 160'({out_valid, in_ready}), 160'(0));
    t_hazard = 1'b0; t_in_valid = 1'b0;

    // STR accepted under flush is dropped, next STR captured
    cnt_before = squash_cnt;
    t_flush = 1'b1;
    send(32'hE5801000, 32'h0000_0300);
    t_flush = 1'b0;
    check("flush_drop", 160'({out_valid, squash_cnt}), 160'({1'b0, cnt_before}));
    send(32'hE5801000, 32'h0000_0304);
    check("str", 160'({out_valid, mem_w_en, src2, two_src}), 160'({1'b1, 1'b1, 4'd1, 1'b1}));

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) send(32'hF3A01005, 32'h400 + 32'(i) * 4);
    check("squash_sat", 160'(squash_cnt), 160'(3));

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      t_rst       = ($urandom_range(0, 99) != 0);
      t_in_valid  = ($urandom_range(0, 9) < 7);
      t_hazard    = ($urandom_range(0, 99) < 15);
      t_flush     = ($urandom_range(0, 9) == 0);
      t_out_ready = ($urandom_range(0, 9) < 7);
      t_status    = 4'($urandom);
      t_instr     = {(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE), 28'($urandom)};
      t_pc        = $urandom;
      t_wb_en     = ($urandom_range(0, 1) == 1);
      t_wb_dest   = 4'($urandom);
      t_wb_value  = $urandom;
      cycle();
    end

    // Load every register, then reset and read them all back as zero
    idle();
    for (int i = 1; i < 16; i++) begin
      t_wb_en = 1'b1; t_wb_dest = 4'(i); t_wb_value = 32'hA500_0000 + 32'(i);
      cycle();
    end
    t_wb_en = 1'b0;
    send(32'hE3A01005, 32'h0000_0500);
    t_rst = 1'b0;
    cycle();
    check("mid_reset", 160'({out_valid, squash_cnt}), 160'(0));
    t_rst = 1'b1;
    for (int i = 1; i < 16; i++) begin
      send(32'hE0800000 | (32'(i) << 16) | 32'(i), 32'h600 + 32'(i) * 4);
      check($sformatf("rf_clear_r%0d", i), 160'({val_rn, val_rm}), 160'(0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
